// File: rtl/gp_bus_fabric.sv
// gp_bus_fabric
// Datapath interconnect for the multicycle processor. It holds:
//   - the general-purpose register file (register 0 is the accumulator, AC)
//   - the PC, IR, MAR and MDR registers
//   - a fixed-priority B-bus source arbiter with conflict detection
//   - a saturating count of bus conflicts
//
// Ports:
//   clk, reset_n            clock; synchronous active-low reset
//   reg_write, reg_read     per-register load enable / B-bus drive request
//   C_Bus                   write-back data from the ALU
//   ac_reset                clear AC (wins over reg_write[0])
//   pc_write, pc_inc        PC load (wins) / increment; IRAM_addr = PC
//   ir_write, ir_read       IR load from FROM_IRAM / IR bus request; IR_out = IR
//   mar_write               MAR load from C_Bus; DMEM_addr = MAR
//   mdr_write, mdr_read     MDR load from C_Bus / MDR bus request; TO_DMEM = MDR
//   dmem_read, FROM_DMEM    data-memory bus request and its data
//   mux_sel, MUX_out        second-operand select; 0 when out of range
//   ALU_IN                  AC value
//   B_Bus, bus_valid        arbitrated bus value and its valid flag
//   conflict, conflict_cnt  more than one requester; saturating 16-bit count
module gp_bus_fabric #(
  parameter int DATA_W  = 24,
  parameter int NREG    = 12,
  parameter int PC_W    = 24,
  parameter int SEL_W   = 5,
  parameter int REG_OUT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREG-1:0]   reg_write,
  input  logic [NREG-1:0]   reg_read,
  input  logic [DATA_W-1:0] C_Bus,
  input  logic              ac_reset,
  input  logic              pc_write,
  input  logic              pc_inc,
  output logic [PC_W-1:0]   IRAM_addr,
  input  logic              ir_write,
  input  logic              ir_read,
  input  logic [DATA_W-1:0] FROM_IRAM,
  output logic [DATA_W-1:0] IR_out,
  input  logic              mar_write,
  output logic [DATA_W-1:0] DMEM_addr,
  input  logic              mdr_write,
  input  logic              mdr_read,
  output logic [DATA_W-1:0] TO_DMEM,
  input  logic              dmem_read,
  input  logic [DATA_W-1:0] FROM_DMEM,
  input  logic [SEL_W-1:0]  mux_sel,
  output logic [DATA_W-1:0] MUX_out,
  output logic [DATA_W-1:0] ALU_IN,
  output logic [DATA_W-1:0] B_Bus,
  output logic              bus_valid,
  output logic              conflict,
  output logic [15:0]       conflict_cnt
);

  localparam int NSRC = NREG + 3;

  logic [DATA_W-1:0] regs [NREG];
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [15:0]       cnt;

  logic [PC_W-1:0]   pc_load;
  logic [NSRC-1:0]   req;
  logic [DATA_W-1:0] bus_c;
  logic              valid_c;
  logic              conflict_c;
  logic [DATA_W-1:0] mux_c;

  // PC load value: zero-extend when PC is wider than the data path.
  if (PC_W > DATA_W) begin : g_pc_ext
    assign pc_load = {{(PC_W-DATA_W){1'b0}}, C_Bus};
  end else begin : g_pc_trunc
    assign pc_load = C_Bus[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_write[i]) regs[i] <= C_Bus;
      end
      if (ac_reset) regs[0] <= '0;
      if (pc_write)    pc <= pc_load;
      else if (pc_inc) pc <= pc + PC_W'(1);
      if (ir_write)  ir  <= FROM_IRAM;
      if (mar_write) mar <= C_Bus;
      if (mdr_write) mdr <= C_Bus;
      if (conflict_c && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
    end
  end

  // Request vector ordered so bit 0 is the highest-priority source.
  assign req = {reg_read, mdr_read, ir_read, dmem_read};

  // Later assignments override earlier ones, so scan from lowest priority up.
  always_comb begin
    bus_c = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (reg_read[i]) bus_c = regs[i];
    end
    if (mdr_read)  bus_c = mdr;
    if (ir_read)   bus_c = ir;
    if (dmem_read) bus_c = FROM_DMEM;
  end

  assign valid_c = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign conflict_c = |(req & (req - NSRC'(1)));

  always_comb begin
    mux_c = '0;
    for (int i = 0; i < NREG; i++) begin
      if (mux_sel == SEL_W'(i)) mux_c = regs[i];
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_W-1:0] bus_q;
    logic              valid_q;
    logic              conflict_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        bus_q      <= '0;
        valid_q    <= 1'b0;
        conflict_q <= 1'b0;
      end else begin
        bus_q      <= bus_c;
        valid_q    <= valid_c;
        conflict_q <= conflict_c;
      end
    end

    assign B_Bus     = bus_q;
    assign bus_valid = valid_q;
    assign conflict  = conflict_q;
  end else begin : g_comb_out
    assign B_Bus     = bus_c;
    assign bus_valid = valid_c;
    assign conflict  = conflict_c;
  end

  assign IRAM_addr    = pc;
  assign IR_out       = ir;
  assign DMEM_addr    = mar;
  assign TO_DMEM      = mdr;
  assign ALU_IN       = regs[0];
  assign MUX_out      = mux_c;
  assign conflict_cnt = cnt;

endmodule

// File: tb/tb_gp_bus_fabric.sv
module tb_gp_bus_fabric;

  localparam int DATA_W = 24;
  localparam int NREG   = 12;
  localparam int PC_W   = 24;
  localparam int SEL_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREG-1:0]   reg_write, reg_read;
  logic [DATA_W-1:0] C_Bus;
  logic              ac_reset, pc_write, pc_inc;
  logic [PC_W-1:0]   IRAM_addr;
  logic              ir_write, ir_read;
  logic [DATA_W-1:0] FROM_IRAM, IR_out;
  logic              mar_write;
  logic [DATA_W-1:0] DMEM_addr;
  logic              mdr_write, mdr_read;
  logic [DATA_W-1:0] TO_DMEM;
  logic              dmem_read;
  logic [DATA_W-1:0] FROM_DMEM;
  logic [SEL_W-1:0]  mux_sel;
  logic [DATA_W-1:0] MUX_out, ALU_IN, B_Bus;
  logic              bus_valid, conflict;
  logic [15:0]       conflict_cnt;

  always #5 clk = ~clk;

  gp_bus_fabric #(
    .DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .SEL_W(SEL_W), .REG_OUT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .reg_read(reg_read),
    .C_Bus(C_Bus), .ac_reset(ac_reset), .pc_write(pc_write), .pc_inc(pc_inc),
    .IRAM_addr(IRAM_addr), .ir_write(ir_write), .ir_read(ir_read),
    .FROM_IRAM(FROM_IRAM), .IR_out(IR_out), .mar_write(mar_write),
    .DMEM_addr(DMEM_addr), .mdr_write(mdr_write), .mdr_read(mdr_read),
    .TO_DMEM(TO_DMEM), .dmem_read(dmem_read), .FROM_DMEM(FROM_DMEM),
    .mux_sel(mux_sel), .MUX_out(MUX_out), .ALU_IN(ALU_IN), .B_Bus(B_Bus),
    .bus_valid(bus_valid), .conflict(conflict), .conflict_cnt(conflict_cnt)
  );

  // Reference model state
  logic [DATA_W-1:0] m_reg [NREG];
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_ir, m_mar, m_mdr;
  logic [15:0]       m_cnt;
  logic [DATA_W-1:0] m_b;
  logic              m_valid, m_conf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge of the specified behaviour, from the current inputs.
  task automatic model_edge();
    logic [DATA_W-1:0] srcs[$];
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_cnt = '0;
      m_b = '0; m_valid = 1'b0; m_conf = 1'b0;
      return;
    end
    // Requesting sources in priority order; the first one wins.
    if (dmem_read) srcs.push_back(FROM_DMEM);
    if (ir_read)   srcs.push_back(m_ir);
    if (mdr_read)  srcs.push_back(m_mdr);
    for (int i = 0; i < NREG; i++) if (reg_read[i]) srcs.push_back(m_reg[i]);
    m_valid = (srcs.size() > 0);
    m_b     = m_valid ? srcs[0] : '0;
    m_conf  = (srcs.size() > 1);
    if (m_conf && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
    for (int i = 0; i < NREG; i++) if (reg_write[i]) m_reg[i] = C_Bus;
    if (ac_reset) m_reg[0] = '0;
    if (pc_write)    m_pc = C_Bus;
    else if (pc_inc) m_pc = m_pc + 1;
    if (ir_write)  m_ir  = FROM_IRAM;
    if (mar_write) m_mar = C_Bus;
    if (mdr_write) m_mdr = C_Bus;
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] exp_mux;
    exp_mux = (int'(mux_sel) < NREG) ? m_reg[mux_sel] : '0;
    chk("b_bus",     B_Bus,        m_b);
    chk("bus_valid", bus_valid,    m_valid);
    chk("conflict",  conflict,     m_conf);
    chk("cnt",       conflict_cnt, m_cnt);
    chk("iram_addr", IRAM_addr,    m_pc);
    chk("ir_out",    IR_out,       m_ir);
    chk("dmem_addr", DMEM_addr,    m_mar);
    chk("to_dmem",   TO_DMEM,      m_mdr);
    chk("alu_in",    ALU_IN,       m_reg[0]);
    chk("mux_out",   MUX_out,      exp_mux);
  endtask

  // Inputs are set at posedge+1; check at posedge+3, then advance one edge.
  task automatic step();
    #2;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_n = 1'b1; reg_write = '0; reg_read = '0; C_Bus = '0;
    ac_reset = 0; pc_write = 0; pc_inc = 0; ir_write = 0; ir_read = 0;
    FROM_IRAM = '0; mar_write = 0; mdr_write = 0; mdr_read = 0;
    dmem_read = 0; FROM_DMEM = '0; mux_sel = '0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    model_edge();
    @(posedge clk); #1;
    idle();
    step();

    // 1: write reg3, read it next cycle, appears one cycle later
    reg_write[3] = 1'b1; C_Bus = 24'h00ABCD; step();
    idle(); reg_read[3] = 1'b1; mux_sel = 5'd3; step();
    idle();
    #2;
    chk("t1_bbus", B_Bus, 24'h00ABCD);
    chk("t1_valid", bus_valid, 1'b1);
    chk("t1_conf", conflict, 1'b0);
    #0; step();

    // 2: dmem_read vs reg_read[0] conflict, held 3 cycles
    dmem_read = 1; reg_read[0] = 1; FROM_DMEM = 24'h123456;
    step();
    #2;
    chk("t2_bbus", B_Bus, 24'h123456);
    chk("t2_conf", conflict, 1'b1);
    chk("t2_cnt1", conflict_cnt, 16'd1);
    step(); step();
    idle();
    #2;
    chk("t2_cnt3", conflict_cnt, 16'd3);
    step();

    // 3: pc_write beats pc_inc, then wrap
    pc_write = 1; pc_inc = 1; C_Bus = 24'h000010; step();
    idle(); #2; chk("t3_pc", IRAM_addr, 24'h000010); step();
    pc_write = 1; C_Bus = 24'hFFFFFF; step();
    idle(); pc_inc = 1; step();
    idle(); #2; chk("t3_wrap", IRAM_addr, 24'h000000); step();

    // 4: ac_reset beats reg_write[0]
    reg_write[0] = 1; C_Bus = 24'h000055; step();
    idle(); #2; chk("t4_ac", ALU_IN, 24'h000055); step();
    ac_reset = 1; reg_write[0] = 1; C_Bus = 24'h0000FF; step();
    idle(); #2; chk("t4_clr", ALU_IN, 24'h000000); step();

    // 5: read-during-write returns the old value
    reg_write[5] = 1; C_Bus = 24'h000011; step();
    idle(); reg_write[5] = 1; reg_read[5] = 1; C_Bus = 24'h000077; step();
    idle(); reg_read[5] = 1;
    #2; chk("t5_old", B_Bus, 24'h000011); step();
    idle(); #2; chk("t5_new", B_Bus, 24'h000077); step();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset_n   = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREG; i++) begin
        reg_write[i] = ($urandom_range(0, 3) == 0);
        reg_read[i]  = ($urandom_range(0, 15) == 0);
      end
      C_Bus     = DATA_W'($urandom);
      FROM_IRAM = DATA_W'($urandom);
      FROM_DMEM = DATA_W'($urandom);
      ac_reset  = ($urandom_range(0, 9) == 0);
      pc_write  = ($urandom_range(0, 7) == 0);
      pc_inc    = ($urandom_range(0, 1) == 0);
      ir_write  = ($urandom_range(0, 3) == 0);
      mar_write = ($urandom_range(0, 3) == 0);
      mdr_write = ($urandom_range(0, 3) == 0);
      ir_read   = ($urandom_range(0, 5) == 0);
      mdr_read  = ($urandom_range(0, 5) == 0);
      dmem_read = ($urandom_range(0, 5) == 0);
      mux_sel   = SEL_W'($urandom_range(0, 15));
      step();
    end

    // 6: saturation after a long conflict, then reset mid-run
    idle(); dmem_read = 1; ir_read = 1; reg_read[2] = 1;
    repeat (70000) begin
      model_edge();
      @(posedge clk); #1;
    end
    #2; chk("t6_sat", conflict_cnt, 16'hFFFF);
    step();
    #2; chk("t6_hold", conflict_cnt, 16'hFFFF);
    reset_n = 1'b0;
    model_edge();
    @(posedge clk); #1;
    #2;
    chk("t6_rst_bbus",  B_Bus,        '0);
    chk("t6_rst_valid", bus_valid,    1'b0);
    chk("t6_rst_conf",  conflict,     1'b0);
    chk("t6_rst_cnt",   conflict_cnt, 16'h0);
    chk("t6_rst_pc",    IRAM_addr,    '0);
    chk("t6_rst_ac",    ALU_IN,       '0);
    chk("t6_rst_mux",   MUX_out,      '0);
    chk("t6_rst_ir",    IR_out,       '0);
    chk("t6_rst_mar",   DMEM_addr,    '0);
    chk("t6_rst_mdr",   TO_DMEM,      '0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gp_bus_fabric.md
Name: gp_bus_fabric

Overview:
Parametrised datapath interconnect for the multicycle processor. It holds the general-purpose register file, the accumulator (register 0), PC, IR, MAR and MDR. It drives the shared B bus from a fixed-priority source arbiter and accepts C-bus write-back from the ALU. It replaces the fixed 24-bit, fixed-register bus with a configurable width and register count, an optional registered B bus, and bus-conflict detection and counting.

Parameters:
DATA_W, 24, width of every datapath register and bus
NREG, 12, number of general-purpose registers; index 0 is AC; must be 2..32
PC_W, 24, PC / IRAM address width
SEL_W, 5, width of mux_sel; must satisfy 2^SEL_W >= NREG
REG_OUT, 1, 1 = B_Bus registered (1-cycle latency); 0 = combinational

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising clk
reg_write  in  NREG  per-register load enable from C_Bus
reg_read  in  NREG  per-register B-bus drive request
C_Bus  in  DATA_W  ALU result / write-back data
ac_reset  in  1  clear AC (reg 0)
pc_write  in  1  load PC from C_Bus[PC_W-1:0]
pc_inc  in  1  PC += 1
IRAM_addr  out  PC_W  PC value
ir_write  in  1  load IR from FROM_IRAM
ir_read  in  1  IR requests B bus
FROM_IRAM  in  DATA_W  instruction memory data
IR_out  out  DATA_W  IR value (decoder)
mar_write  in  1  load MAR from C_Bus
DMEM_addr  out  DATA_W  MAR value
mdr_write  in  1  load MDR from C_Bus
mdr_read  in  1  MDR requests B bus
TO_DMEM  out  DATA_W  MDR value
dmem_read  in  1  DMEM data requests B bus
FROM_DMEM  in  DATA_W  data memory read data
mux_sel  in  SEL_W  second-operand register select
MUX_out  out  DATA_W  reg[mux_sel]; 0 when mux_sel >= NREG
ALU_IN  out  DATA_W  AC value, always driven
B_Bus  out  DATA_W  selected bus source
bus_valid  out  1  B_Bus carries a selected source
conflict  out  1  more than one source requested
conflict_cnt  out  16  saturating conflict count

Behaviour:
- Reset (reset_n=0 at a rising edge): all registers, PC, IR, MAR, MDR, conflict_cnt = 0. If REG_OUT=1, B_Bus = 0, bus_valid = 0, conflict = 0. Reset overrides every other input that cycle.
- Register writes at the edge: each reg[i] with reg_write[i]=1 loads C_Bus. Multiple simultaneous writes are legal (broadcast).
- AC: ac_reset beats reg_write[0], so AC = 0.
- PC: pc_write beats pc_inc. Increment wraps at 2^PC_W-1 → 0.
- IR loads FROM_IRAM on ir_write. MAR and MDR load C_Bus on their write enables.
- Source priority, highest first: dmem_read, ir_read, mdr_read, reg_read[0], reg_read[1] … reg_read[NREG-1]. The lowest register index wins among registers.
- No source selected: B_Bus = 0 and bus_valid = 0. No tri-state value is ever driven.
- Conflict: the number of asserted requests across all NREG+3 sources is > 1. B_Bus still carries the highest-priority source.
- REG_OUT=0: B_Bus, bus_valid and conflict are combinational from the current requests and current register contents.
- REG_OUT=1: the same three outputs are captured at the edge and appear 1 cycle after the request.
- Read during write: a register read in the same cycle it is written yields its pre-edge value in both modes. There is no write-through path.
- conflict_cnt increments at each edge where the combinational conflict is true. It saturates at 0xFFFF and clears only on reset.
- MUX_out and ALU_IN are combinational reads of current register state. MUX_out is independent of the B-bus arbiter.
- Width rule: on pc_write, PC takes C_Bus[PC_W-1:0]. If PC_W > DATA_W, PC zero-extends C_Bus. IRAM_addr is the PC unchanged.

Test Plan:
1. Reset, then reg_write[3]=1 with C_Bus=24'h00ABCD; next cycle reg_read[3]=1 (REG_OUT=1) → B_Bus=24'h00ABCD one cycle later, bus_valid=1, conflict=0.
2. dmem_read=1, reg_read[0]=1, FROM_DMEM=24'h123456 → B_Bus=24'h123456, conflict=1, conflict_cnt 0→1. Hold for 3 cycles → conflict_cnt=3.
3. Same cycle: pc_write=1, pc_inc=1, C_Bus=24'h000010 → PC=24'h000010. Then PC=24'hFFFFFF with pc_inc → PC=0.
4. AC=24'h000055; ac_reset=1 and reg_write[0]=1, C_Bus=24'h0000FF → ALU_IN=0.
5. reg_write[5]=1 (C_Bus=24'h000077) and reg_read[5]=1 in the same cycle, old value 24'h000011 → B_Bus=24'h000011. The next read returns 24'h000077.
6. Force conflict for 70000 cycles → conflict_cnt holds 16'hFFFF. reset_n=0 mid-run → all outputs 0 at the next edge.
